// File: rtl/crc_serial_engine.sv
// Parametrised serial CRC/LFSR engine: absorbs one frame bit per clock, then
// either shifts the CRC out LSB first (generate) or compares it against DATA (check).
module crc_serial_engine #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAP   = 8'h44,
  parameter logic [WIDTH-1:0] SEED  = 8'hD8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA,
  input  logic       Active,
  input  logic       Check_En,
  output logic       CRC,
  output logic       Valid,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic [1:0] dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_SHIFT = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            crc_q, crc_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            mis_q, mis_d;

  logic             fb;
  logic [WIDTH-1:0] lfsr_upd;
  logic [WIDTH-1:0] lfsr_shr;

  // MSB always takes the feedback, so TAP[WIDTH-1] never participates.
  assign fb       = lfsr_q[0] ^ DATA;
  assign lfsr_upd = {fb, lfsr_q[WIDTH-1:1] ^ (TAP[WIDTH-2:0] & {(WIDTH-1){fb}})};
  assign lfsr_shr = {1'b0, lfsr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    crc_d   = crc_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = err_q;
    mis_d   = mis_q;

    case (state_q)
      S_IDLE: begin
        if (Active) begin
          lfsr_d  = lfsr_upd;
          mode_d  = Check_En;
          err_d   = 1'b0;
          mis_d   = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (Active) begin
          lfsr_d = lfsr_upd;
        end else if (!mode_q) begin
          crc_d   = lfsr_q[0];
          lfsr_d  = lfsr_shr;
          valid_d = 1'b1;
          cnt_d   = CW'(1);
          state_d = S_SHIFT;
        end else begin
          mis_d   = DATA ^ lfsr_q[0];
          lfsr_d  = lfsr_shr;
          cnt_d   = CW'(1);
          state_d = S_CHECK;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          crc_d   = 1'b0;
          valid_d = 1'b0;
          done_d  = 1'b1;
          lfsr_d  = SEED;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          crc_d  = lfsr_q[0];
          lfsr_d = lfsr_shr;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (cnt_q == CNT_LAST) begin
          err_d   = mis_q;
          done_d  = 1'b1;
          lfsr_d  = SEED;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          mis_d  = mis_q | (DATA ^ lfsr_q[0]);
          lfsr_d = lfsr_shr;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Busy is registered from the next state so it lines up with the state flop.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      crc_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      crc_q   <= crc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign CRC         = crc_q;
  assign Valid       = valid_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: default 8-bit instance plus a 16-bit
// instance checked against a bench-side CRC model on fixed 32-bit frames.
module tb_crc_serial_engine;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  logic       data, active, check_en;
  logic       crc, valid, busy, done, err;
  logic [1:0] dbg_state;

  logic       data16, active16, check16;
  logic       crc16, valid16, busy16, done16, err16;
  logic [1:0] dbg_state16;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  crc_serial_engine u_dut (
    .CLK(CLK), .RST(RST), .DATA(data), .Active(active), .Check_En(check_en),
    .CRC(crc), .Valid(valid), .Busy(busy), .Done(done), .Err(err),
    .dbg_state_o(dbg_state)
  );

  crc_serial_engine #(.WIDTH(16), .TAP(16'h1021), .SEED(16'hFFFF)) u_dut16 (
    .CLK(CLK), .RST(RST), .DATA(data16), .Active(active16), .Check_En(check16),
    .CRC(crc16), .Valid(valid16), .Busy(busy16), .Done(done16), .Err(err16),
    .dbg_state_o(dbg_state16)
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  // One-bit generate frame; returns at the negedge where Done is seen (or on timeout).
  task automatic run_gen(input logic d, input logic noise, output logic [7:0] word,
                         output int vcnt, output int done_at, output logic err_first,
                         output logic busy_end);
    word = '0; vcnt = 0; done_at = 0; busy_end = 1'b1;
    active = 1'b1; data = d; check_en = 1'b0;
    tick();
    err_first = err;
    active = 1'b0; data = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        done_at  = k;
        busy_end = busy;
        break;
      end
      if (valid) begin
        if (vcnt < 8) word[vcnt] = crc;
        vcnt++;
      end
      if (noise) begin
        active = 1'b1;
        data   = 1'($urandom_range(0, 1));
      end
    end
    active = 1'b0; data = 1'b0;
  endtask

  task automatic run_check(input logic [7:0] word, output logic err_o, output int done_at,
                           output logic valid_seen);
    done_at = 0; err_o = 1'b0; valid_seen = 1'b0;
    active = 1'b1; data = 1'b0; check_en = 1'b1;
    tick();
    active = 1'b0; check_en = 1'b0; data = word[0];
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (valid) valid_seen = 1'b1;
      if (done) begin
        done_at = k;
        err_o   = err;
        break;
      end
      data = (k < 8) ? word[k] : 1'b0;
    end
    data = 1'b0;
  endtask

  function automatic logic [15:0] model16(input logic [31:0] frame);
    logic [15:0] l, n, tap;
    logic        f;
    l   = 16'hFFFF;
    tap = 16'h1021;
    for (int i = 0; i < 32; i++) begin
      f = l[0] ^ frame[i];
      for (int j = 0; j < 15; j++) n[j] = l[j+1] ^ (tap[j] & f);
      n[15] = f;
      l = n;
    end
    return l;
  endfunction

  task automatic test_reset();
    logic [7:0] w; int vc, da; logic ef, be;
    tick();
    total++;
    if ({crc, valid, busy, done, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_values got crc/valid/busy/done/err=%b want 00000", {crc, valid, busy, done, err});
    end
    RST = 1'b1;
    tick();
    active = 1'b1; data = 1'b0; check_en = 1'b0;
    tick();
    active = 1'b0;
    tick(); tick(); tick();
    total++;
    if (valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_shift_setup got valid=%b want 1", valid);
    end
    RST = 1'b0;
    #1;
    total++;
    if ({crc, valid, busy, done, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_async got crc/valid/busy/done/err=%b want 00000", {crc, valid, busy, done, err});
    end
    tick();
    total++;
    if ({crc, valid, busy, done, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_hold got crc/valid/busy/done/err=%b want 00000", {crc, valid, busy, done, err});
    end
    RST = 1'b1;
    tick();
    run_gen(1'b0, 1'b0, w, vc, da, ef, be);
    total++;
    if (w !== 8'h6C || vc != 8 || da != 9) begin
      bad++;
      $display("FAIL reset_recover got crc=%h vcnt=%0d done_at=%0d want 6c 8 9", w, vc, da);
    end
  endtask

  task automatic test_gen();
    logic [7:0] w; int vc, da; logic ef, be;
    run_gen(1'b0, 1'b0, w, vc, da, ef, be);
    total++;
    if (w !== 8'h6C) begin
      bad++;
      $display("FAIL gen0_crc got %h want 6c", w);
    end
    total++;
    if (vc != 8 || da != 9) begin
      bad++;
      $display("FAIL gen0_timing got vcnt=%0d done_at=%0d want 8 9", vc, da);
    end
    total++;
    if (be !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL gen0_busy_end got busy=%b valid=%b want 0 0", be, valid);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL gen0_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
    run_gen(1'b1, 1'b0, w, vc, da, ef, be);
    total++;
    if (w !== 8'hA8 || vc != 8 || da != 9) begin
      bad++;
      $display("FAIL gen1_crc got crc=%h vcnt=%0d done_at=%0d want a8 8 9", w, vc, da);
    end
    tick();
  endtask

  task automatic test_zero_frame();
    logic seen;
    seen = 1'b0;
    active = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (valid || busy || done) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL zero_frame got activity=%b state=%0d want 0 0", seen, dbg_state);
    end
  endtask

  task automatic test_check();
    logic e, vs; int da;
    logic [7:0] w; int vc, gda; logic ef, be;
    run_check(8'h6C, e, da, vs);
    total++;
    if (da != 9 || e !== 1'b0 || vs !== 1'b0) begin
      bad++;
      $display("FAIL check_good got done_at=%0d err=%b valid_seen=%b want 9 0 0", da, e, vs);
    end
    tick();
    run_check(8'h64, e, da, vs);
    total++;
    if (da != 9 || e !== 1'b1 || vs !== 1'b0) begin
      bad++;
      $display("FAIL check_bad got done_at=%0d err=%b valid_seen=%b want 9 1 0", da, e, vs);
    end
    tick(); tick(); tick();
    total++;
    if (err !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL check_err_hold got err=%b done=%b want 1 0", err, done);
    end
    run_gen(1'b0, 1'b0, w, vc, gda, ef, be);
    total++;
    if (ef !== 1'b0 || w !== 8'h6C) begin
      bad++;
      $display("FAIL check_err_clear got err=%b crc=%h want 0 6c", ef, w);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w; int vc, da; logic ef, be;
    run_gen(1'b0, 1'b0, w, vc, da, ef, be);
    run_gen(1'b1, 1'b0, w, vc, da, ef, be);
    total++;
    if (w !== 8'hA8 || vc != 8 || da != 9) begin
      bad++;
      $display("FAIL b2b_second got crc=%h vcnt=%0d done_at=%0d want a8 8 9", w, vc, da);
    end
    tick();
    run_gen(1'b0, 1'b1, w, vc, da, ef, be);
    total++;
    if (w !== 8'h6C || vc != 8 || da != 9) begin
      bad++;
      $display("FAIL shift_active_ignored got crc=%h vcnt=%0d done_at=%0d want 6c 8 9", w, vc, da);
    end
    tick();
    total++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL done_edge_active got busy=%b state=%0d want 0 0", busy, dbg_state);
    end
  endtask

  task automatic test_width16();
    logic [31:0] frames [3];
    logic [15:0] w, exp_w;
    int vc, da;
    frames[0] = 32'h0000_0000;
    frames[1] = 32'hDEAD_BEEF;
    frames[2] = 32'h1234_5678;
    for (int f = 0; f < 3; f++) begin
      exp_w = model16(frames[f]);
      w = '0; vc = 0; da = 0;
      for (int i = 0; i < 32; i++) begin
        active16 = 1'b1; data16 = frames[f][i];
        tick();
      end
      active16 = 1'b0; data16 = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (done16) begin
          da = k;
          break;
        end
        if (valid16) begin
          if (vc < 16) w[vc] = crc16;
          vc++;
        end
      end
      total++;
      if (w !== exp_w) begin
        bad++;
        $display("FAIL w16_crc frame=%0d got %h want %h", f, w, exp_w);
      end
      total++;
      if (vc != 16 || da != 17) begin
        bad++;
        $display("FAIL w16_timing frame=%0d got vcnt=%0d done_at=%0d want 16 17", f, vc, da);
      end
      tick();
    end
  endtask

  initial begin
    data = 1'b0; active = 1'b0; check_en = 1'b0;
    data16 = 1'b0; active16 = 1'b0; check16 = 1'b0;
    test_reset();
    test_gen();
    test_zero_frame();
    test_check();
    test_back_to_back();
    test_width16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
